// File: rtl/saturate_clip.sv
// saturate_clip: registered unsigned saturating narrower with overflow status; define SAT_OVF_CNT_EN to build the 16-bit overflow counter
module saturate_clip #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [15:0]      ovf_cnt
);
  localparam logic [IN_W-1:0] MAXV = IN_W'(2 ** OUT_W - 1);
  logic             sat;
  logic [OUT_W-1:0] clampv;
  logic             hit;
  // Clamp anything above the output range to all-ones; with IN_W == OUT_W sat folds to 0
  always_comb begin
    sat    = din > MAXV;
    clampv = sat ? MAXV[OUT_W-1:0] : din[OUT_W-1:0];
    hit    = in_valid & sat;
  end
  // Output stage: dout/ovf only load on valid samples, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      dout      <= in_valid ? clampv : dout;
      ovf       <= in_valid ? sat : ovf;
    end
  end
  // Sticky flag: a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) ovf_sticky <= 1'b0;
    else     ovf_sticky <= hit | (ovf_sticky & ~clr_sticky);
  end
`ifdef SAT_OVF_CNT_EN
  // Overflow counter: saturates at all-ones, clear-with-overflow leaves 1
  always_ff @(posedge clk) begin
    if (rst)             ovf_cnt <= '0;
    else if (clr_sticky) ovf_cnt <= {15'd0, hit};
    else if (hit)        ovf_cnt <= (&ovf_cnt) ? ovf_cnt : ovf_cnt + 16'd1;
  end
`else
  assign ovf_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_saturate_clip.sv
// tb_saturate_clip: directed plus random checks of saturate_clip against an arithmetic reference model
module tb_saturate_clip;
  localparam int IN_W  = 10;
  localparam int OUT_W = 8;
  localparam int MAXV  = 2 ** OUT_W - 1;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  din = '0;
  logic             clr_sticky = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] dout;
  logic             ovf;
  logic             ovf_sticky;
  logic [15:0]      ovf_cnt;
  int tests = 0;
  int fails = 0;
  int m_ov = 0, m_dout = 0, m_ovf = 0, m_sticky = 0, m_cnt = 0;
  saturate_clip #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr_sticky(clr_sticky),
    .out_valid(out_valid), .dout(dout), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag);
    tests += 5;
    assert (out_valid === 1'(m_ov)) else begin
      fails++; $error("FAIL %s out_valid got %b want %0d", tag, out_valid, m_ov);
    end
    assert (dout === OUT_W'(m_dout)) else begin
      fails++; $error("FAIL %s dout got %0d want %0d", tag, dout, m_dout);
    end
    assert (ovf === 1'(m_ovf)) else begin
      fails++; $error("FAIL %s ovf got %b want %0d", tag, ovf, m_ovf);
    end
    assert (ovf_sticky === 1'(m_sticky)) else begin
      fails++; $error("FAIL %s ovf_sticky got %b want %0d", tag, ovf_sticky, m_sticky);
    end
    assert (ovf_cnt === 16'(m_cnt)) else begin
      fails++; $error("FAIL %s ovf_cnt got %0d want %0d", tag, ovf_cnt, m_cnt);
    end
  endtask
  task automatic step(input string tag, input bit r, input bit v, input int d, input bit c, input bit chk = 1'b1);
    bit over;
    rst = r; in_valid = v; din = IN_W'(d); clr_sticky = c;
    @(posedge clk);
    over = v && (d > MAXV);
    if (r) begin
      m_ov = 0; m_dout = 0; m_ovf = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_ov = v;
      if (v) begin
        m_dout = over ? MAXV : d;
        m_ovf  = over;
      end
      m_sticky = over ? 1 : (c ? 0 : m_sticky);
`ifdef SAT_OVF_CNT_EN
      m_cnt = c ? int'(over) : (over && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
`endif
    end
    #1;
    if (chk) check(tag);
  endtask
  initial begin
    step("reset", 1, 1, 700, 0);
    step("reset2", 1, 0, 0, 0);
    step("pass200", 0, 1, 200, 0);
    step("maxv", 0, 1, 255, 0);
    step("maxv_plus1", 0, 1, 256, 0);
    step("top", 0, 1, 1023, 0);
    step("hold", 0, 0, 5, 0);
    step("zero", 0, 1, 0, 0);
    step("clr_idle", 0, 0, 0, 1);
    step("ovf_again", 0, 1, 300, 0);
    step("clr_idle2", 0, 0, 0, 1);
    step("clr_and_ovf", 0, 1, 300, 1);
    step("mid_reset", 1, 1, 700, 0);
    step("after_reset", 0, 1, 17, 0);
    for (int i = 0; i < 3; i++) step("cnt3", 0, 1, 256 + i * 100, 0);
    step("clr_cnt", 0, 1, 10, 1);
    for (int i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 2 ** IN_W - 1),
           ($urandom_range(0, 9) == 0));
`ifdef SAT_OVF_CNT_EN
    step("pre_sat_clr", 0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) step("sat_run", 0, 1, 512, 0, (i % 1000) == 0);
    step("cnt_saturated", 0, 1, 1023, 0);
    step("cnt_clr_ovf", 0, 1, 1023, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
